// File: rtl/axis_demux_pkt.sv
// axis_demux_pkt: packet-aware 1-to-3 AXI4-Stream demultiplexer with drop route.
// The route is sampled from sel on the first beat of each packet and held until
// tlast. A registered output stage backed by a one-entry skid buffer gives one
// beat per cycle with a registered s_axis_tready. Route 3 discards packets and
// counts them in a saturating 16-bit counter.
module axis_demux_pkt #(
  parameter int unsigned DATAW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           sel,

  input  logic [DATAW-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tuser,
  input  logic                 s_axis_tlast,
  input  logic [DATAW/8-1:0]   s_axis_tkeep,

  output logic [DATAW-1:0]     m0_axis_tdata,
  output logic                 m0_axis_tvalid,
  input  logic                 m0_axis_tready,
  output logic                 m0_axis_tuser,
  output logic                 m0_axis_tlast,
  output logic [DATAW/8-1:0]   m0_axis_tkeep,

  output logic [DATAW-1:0]     m1_axis_tdata,
  output logic                 m1_axis_tvalid,
  input  logic                 m1_axis_tready,
  output logic                 m1_axis_tuser,
  output logic                 m1_axis_tlast,
  output logic [DATAW/8-1:0]   m1_axis_tkeep,

  output logic [DATAW-1:0]     m2_axis_tdata,
  output logic                 m2_axis_tvalid,
  input  logic                 m2_axis_tready,
  output logic                 m2_axis_tuser,
  output logic                 m2_axis_tlast,
  output logic [DATAW/8-1:0]   m2_axis_tkeep,

  output logic [15:0]          drop_cnt
);

  localparam int unsigned KEEPW    = DATAW / 8;
  localparam int unsigned ROUTEW   = 2;
  localparam int unsigned CNTW     = 16;
  localparam logic [ROUTEW-1:0] ROUTE_DROP = ROUTEW'(3);
  localparam logic [CNTW-1:0]   CNT_MAX    = {CNTW{1'b1}};

  // Packet tracking
  logic              r_in_pkt;
  logic [ROUTEW-1:0] r_route_cur;

  // Output register
  logic              r_out_valid;
  logic [DATAW-1:0]  r_out_data;
  logic              r_out_user;
  logic              r_out_last;
  logic [KEEPW-1:0]  r_out_keep;
  logic [ROUTEW-1:0] r_out_route;

  // Skid register
  logic              r_skid_valid;
  logic [DATAW-1:0]  r_skid_data;
  logic              r_skid_user;
  logic              r_skid_last;
  logic [KEEPW-1:0]  r_skid_keep;
  logic [ROUTEW-1:0] r_skid_route;

  logic              r_tready;
  logic [CNTW-1:0]   r_drop_cnt;

  logic              w_accept;
  logic [ROUTEW-1:0] w_beat_route;
  logic              w_out_ready;
  logic              w_load;
  logic              w_retire;
  logic              w_skid_next;

  assign w_accept     = s_axis_tvalid && r_tready;
  assign w_beat_route = r_in_pkt ? r_route_cur : sel;

  // Ready of whichever master the head beat is routed to; the drop route always retires.
  always_comb begin
    w_out_ready = 1'b1;
    case (r_out_route)
      2'd0:    w_out_ready = m0_axis_tready;
      2'd1:    w_out_ready = m1_axis_tready;
      2'd2:    w_out_ready = m2_axis_tready;
      default: w_out_ready = 1'b1;
    endcase
  end

  assign w_load      = !r_out_valid || w_out_ready;
  assign w_retire    = r_out_valid && w_out_ready;
  // Skid is emptied whenever the output register can load; otherwise it catches an accepted beat.
  assign w_skid_next = !w_load && (r_skid_valid || w_accept);

  // Track packet boundaries and latch the route on the first beat of each packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_pkt    <= 1'b0;
      r_route_cur <= '0;
    end else if (w_accept) begin
      if (!r_in_pkt) begin
        r_route_cur <= sel;
      end
      r_in_pkt <= !s_axis_tlast;
    end
  end

  // Output register and skid buffer; skid drains first so beat order is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_user   <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_keep   <= '0;
      r_out_route  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_user  <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_keep  <= '0;
      r_skid_route <= '0;
    end else begin
      if (w_load) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_user   <= r_skid_user;
          r_out_last   <= r_skid_last;
          r_out_keep   <= r_skid_keep;
          r_out_route  <= r_skid_route;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= s_axis_tdata;
          r_out_user   <= s_axis_tuser;
          r_out_last   <= s_axis_tlast;
          r_out_keep   <= s_axis_tkeep;
          r_out_route  <= w_beat_route;
        end else begin
          r_out_valid  <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= s_axis_tdata;
        r_skid_user  <= s_axis_tuser;
        r_skid_last  <= s_axis_tlast;
        r_skid_keep  <= s_axis_tkeep;
        r_skid_route <= w_beat_route;
      end
    end
  end

  // Registered input ready: open exactly when the skid will be empty next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= !w_skid_next;
    end
  end

  // Count dropped packets as their last beat retires, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_retire && (r_out_route == ROUTE_DROP) && r_out_last &&
                 (r_drop_cnt != CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + CNTW'(1);
    end
  end

  assign s_axis_tready  = r_tready;
  assign drop_cnt       = r_drop_cnt;

  assign m0_axis_tvalid = r_out_valid && (r_out_route == 2'd0);
  assign m1_axis_tvalid = r_out_valid && (r_out_route == 2'd1);
  assign m2_axis_tvalid = r_out_valid && (r_out_route == 2'd2);

  assign m0_axis_tdata  = r_out_data;
  assign m0_axis_tuser  = r_out_user;
  assign m0_axis_tlast  = r_out_last;
  assign m0_axis_tkeep  = r_out_keep;
  assign m1_axis_tdata  = r_out_data;
  assign m1_axis_tuser  = r_out_user;
  assign m1_axis_tlast  = r_out_last;
  assign m1_axis_tkeep  = r_out_keep;
  assign m2_axis_tdata  = r_out_data;
  assign m2_axis_tuser  = r_out_user;
  assign m2_axis_tlast  = r_out_last;
  assign m2_axis_tkeep  = r_out_keep;

endmodule

// File: tb/tb_axis_demux_pkt.sv
// Directed testbench for axis_demux_pkt: routing, sel hold, backpressure, drop, reset, saturation.
module tb_axis_demux_pkt;

  localparam int unsigned DATAW = 24;
  localparam int unsigned KEEPW = DATAW / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       sel = 2'd0;
  logic [DATAW-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_tready;
  logic             s_user = 1'b0;
  logic             s_last = 1'b0;
  logic [KEEPW-1:0] s_keep = '0;

  logic [DATAW-1:0] m0_data, m1_data, m2_data;
  logic             m0_valid, m1_valid, m2_valid;
  logic             m0_ready = 1'b1, m1_ready = 1'b1, m2_ready = 1'b1;
  logic             m0_user, m1_user, m2_user;
  logic             m0_last, m1_last, m2_last;
  logic [KEEPW-1:0] m0_keep, m1_keep, m2_keep;
  logic [15:0]      drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_demux_pkt #(.DATAW(DATAW)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_user), .s_axis_tlast(s_last), .s_axis_tkeep(s_keep),
    .m0_axis_tdata(m0_data), .m0_axis_tvalid(m0_valid), .m0_axis_tready(m0_ready),
    .m0_axis_tuser(m0_user), .m0_axis_tlast(m0_last), .m0_axis_tkeep(m0_keep),
    .m1_axis_tdata(m1_data), .m1_axis_tvalid(m1_valid), .m1_axis_tready(m1_ready),
    .m1_axis_tuser(m1_user), .m1_axis_tlast(m1_last), .m1_axis_tkeep(m1_keep),
    .m2_axis_tdata(m2_data), .m2_axis_tvalid(m2_valid), .m2_axis_tready(m2_ready),
    .m2_axis_tuser(m2_user), .m2_axis_tlast(m2_last), .m2_axis_tkeep(m2_keep),
    .drop_cnt(drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0; s_data = '0; s_keep = '0;
    sel = 2'd0; m0_ready = 1'b1; m1_ready = 1'b1; m2_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", s_tready); end
    checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b000) begin errors++; $display("FAIL reset_tvalid: got %b expected 000", {m0_valid, m1_valid, m2_valid}); end
    checks++; if ({m0_data, m0_user, m0_last, m0_keep} !== '0) begin errors++; $display("FAIL reset_payload: got %h/%b/%b/%h expected 0", m0_data, m0_user, m0_last, m0_keep); end
    checks++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt); end
    rst = 1'b0;
    step();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready_rise: got %b expected 1", s_tready); end
  endtask

  task automatic test_route_m1();
    logic [KEEPW-1:0] keep;
    do_reset();
    sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      keep = (i == 3) ? 3'b011 : 3'b111;
      s_valid = 1'b1; s_data = 24'(i + 1); s_last = (i == 3); s_user = (i == 0); s_keep = keep;
      step();
      checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b010) begin errors++; $display("FAIL m1_valid beat%0d: got %b expected 010", i, {m0_valid, m1_valid, m2_valid}); end
      checks++; if (m1_data !== 24'(i + 1)) begin errors++; $display("FAIL m1_data beat%0d: got %h expected %h", i, m1_data, 24'(i + 1)); end
      checks++; if ({m1_last, m1_user, m1_keep} !== {(i == 3), (i == 0), keep}) begin errors++; $display("FAIL m1_side beat%0d: got %b%b%b expected %b%b%b", i, m1_last, m1_user, m1_keep, (i == 3), (i == 0), keep); end
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL m1_tready beat%0d: got %b expected 1", i, s_tready); end
    end
    s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
    step();
    checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b000) begin errors++; $display("FAIL m1_drain: got %b expected 000", {m0_valid, m1_valid, m2_valid}); end
  endtask

  task automatic test_sel_hold();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0) ? 2'd0 : 2'd2;
      s_valid = 1'b1; s_data = 24'(16 + i); s_last = (i == 2);
      step();
      checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b100 || m0_data !== 24'(16 + i)) begin errors++; $display("FAIL sel_hold beat%0d: got %b/%h expected 100/%h", i, {m0_valid, m1_valid, m2_valid}, m0_data, 24'(16 + i)); end
    end
    sel = 2'd2; s_data = 24'h000099; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b001 || m2_data !== 24'h000099 || m2_last !== 1'b1) begin errors++; $display("FAIL back_to_back_m2: got %b/%h/%b expected 001/000099/1", {m0_valid, m1_valid, m2_valid}, m2_data, m2_last); end
    step();
  endtask

  task automatic test_backpressure();
    int in_idx = 0;
    int out_idx = 0;
    do_reset();
    sel = 2'd2;
    for (int cyc = 0; cyc < 14; cyc++) begin
      s_valid = (in_idx < 6); s_data = 24'(32 + in_idx); s_last = (in_idx == 5);
      m2_ready = !(cyc >= 1 && cyc <= 3);
      if (cyc == 1) begin checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_tready_c1: got %b expected 1", s_tready); end end
      if (cyc == 2) begin checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_tready_c2: got %b expected 0", s_tready); end end
      if (cyc == 4) begin checks++; if (s_tready !== 1'b0 || m2_valid !== 1'b1 || m2_data !== 24'h000020) begin errors++; $display("FAIL bp_hold_c4: got %b/%b/%h expected 0/1/000020", s_tready, m2_valid, m2_data); end end
      if (cyc == 5) begin checks++; if (s_tready !== 1'b1 || m2_data !== 24'h000021) begin errors++; $display("FAIL bp_resume_c5: got %b/%h expected 1/000021", s_tready, m2_data); end end
      checks++; if (m0_valid !== 1'b0 || m1_valid !== 1'b0) begin errors++; $display("FAIL bp_other_valid c%0d: got %b%b expected 00", cyc, m0_valid, m1_valid); end
      if (m2_valid && m2_ready) begin
        checks++; if (m2_data !== 24'(32 + out_idx) || m2_last !== (out_idx == 5)) begin errors++; $display("FAIL bp_order idx%0d: got %h/%b expected %h/%b", out_idx, m2_data, m2_last, 24'(32 + out_idx), (out_idx == 5)); end
        out_idx++;
      end
      if (s_valid && s_tready) in_idx++;
      step();
    end
    m2_ready = 1'b1;
    checks++; if (out_idx != 6 || in_idx != 6) begin errors++; $display("FAIL bp_count: got out %0d in %0d expected 6 6", out_idx, in_idx); end
  endtask

  task automatic test_drop();
    int in_idx = 0;
    do_reset();
    sel = 2'd3;
    for (int cyc = 0; cyc < 13; cyc++) begin
      s_valid = (in_idx < 10); s_data = 24'(64 + in_idx); s_last = (in_idx % 5 == 4);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL drop_tready c%0d: got %b expected 1", cyc, s_tready); end
      checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b000) begin errors++; $display("FAIL drop_valid c%0d: got %b expected 000", cyc, {m0_valid, m1_valid, m2_valid}); end
      if (s_valid && s_tready) in_idx++;
      step();
    end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d expected 2", drop_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    sel = 2'd0; s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data = 24'(49 + i); s_last = 1'b0;
      step();
    end
    s_data = 24'h000033; sel = 2'd1;
    rst = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0 || {m0_valid, m1_valid, m2_valid} !== 3'b000 || m0_data !== '0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_async: got %b/%b/%h/%h expected 0/000/0/0", s_tready, {m0_valid, m1_valid, m2_valid}, m0_data, drop_cnt); end
    step();
    checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b000 || s_tready !== 1'b0) begin errors++; $display("FAIL rst_mid_hold: got %b/%b expected 000/0", {m0_valid, m1_valid, m2_valid}, s_tready); end
    rst = 1'b0; s_data = 24'h000044; s_last = 1'b1; sel = 2'd1;
    step();
    checks++; if (s_tready !== 1'b1 || {m0_valid, m1_valid, m2_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_rise: got %b/%b expected 1/000", s_tready, {m0_valid, m1_valid, m2_valid}); end
    step();
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if ({m0_valid, m1_valid, m2_valid} !== 3'b010 || m1_data !== 24'h000044) begin errors++; $display("FAIL rst_mid_route: got %b/%h expected 010/000044", {m0_valid, m1_valid, m2_valid}, m1_data); end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    sel = 2'd3; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      s_data = 24'(i);
      step();
    end
    s_valid = 1'b0;
    step(); step();
    checks++; if (drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", drop_cnt); end
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step(); step();
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", drop_cnt); end
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step(); step();
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_route_m1();
    test_sel_hold();
    test_backpressure();
    test_drop();
    test_reset_mid_packet();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_demux_pkt.md
# axis_demux_pkt

Packet-aware 1-to-3 AXI4-Stream demultiplexer: routes one slave stream to one of three master streams, or drops it, using a select that is sampled on the first beat of each packet and held until `tlast`. It is the fan-out counterpart of the simple 3-to-1 stream switch in the video/audio datapath. A registered output stage with a skid buffer gives one-beat-per-cycle throughput and registered `tready`.

## Interface
- `DATAW`, 24, tdata width in bits; multiple of 8.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sel`  in  2  route for next packet: 0/1/2 = m0/m1/m2, 3 = drop.
- `s_axis_tdata`  in  DATAW  input data.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready; registered.
- `s_axis_tuser`  in  1  input user bit (start of frame).
- `s_axis_tlast`  in  1  input end of packet.
- `s_axis_tkeep`  in  DATAW/8  input byte qualifiers.
- `mN_axis_tdata`  out  DATAW  output data (N = 0,1,2), shared output register.
- `mN_axis_tvalid`  out  1  output valid; only the routed master is asserted.
- `mN_axis_tready`  in  1  output ready.
- `mN_axis_tuser`, `mN_axis_tlast`  out  1  shared output register.
- `mN_axis_tkeep`  out  DATAW/8  shared output register.
- `drop_cnt`  out  16  saturating count of dropped packets.

## Operation
- Beat accepted when `s_axis_tvalid && s_axis_tready`.
- Packet tracking: flag `in_pkt` (reset 0) and register `route_cur` (reset 0).
  - Accepted beat with `in_pkt=0`: beat route = `sel`; `route_cur <= sel`; `in_pkt <= !s_axis_tlast`.
  - Accepted beat with `in_pkt=1`: beat route = `route_cur`; `in_pkt <= !s_axis_tlast`.
  - `sel` changes while `in_pkt=1` are ignored.
  - A single-beat packet (tlast on its first beat) leaves `in_pkt=0`.
- Datapath: output register (`out_valid`, payload, `out_route`) plus one skid register (`skid_valid`, payload, route).
  - `out_ready` = `mR_axis_tready` for `out_route`=R in 0..2; 1 when `out_route`=3, so dropped beats retire in one cycle.
  - When `!out_valid || out_ready`: load the output register from skid if `skid_valid` (clear skid), else from an accepted input beat, else clear `out_valid`.
  - Otherwise an accepted input beat goes to skid.
  - `s_axis_tready` next = !`skid_valid` next.
- `mN_axis_tvalid` = `out_valid && out_route==N`. The payload outputs of all three masters carry the same output register.
- `drop_cnt` increments when a beat with `out_route=3` and `tlast=1` retires; it holds at 0xFFFF.
- No reordering and no beat loss except on route 3. Packets leave in input order, even when they go to different masters.

## Timing
- Reset values: `s_axis_tready`=0, all `mN_axis_tvalid`=0, all payload outputs 0, `drop_cnt`=0; `in_pkt`, `skid_valid` and `out_valid` = 0.
- `s_axis_tready` rises on the first `clk` edge after `rst` deasserts.
- Latency: an accepted beat appears on its master on the next cycle when the output register is empty or draining.
- Throughput: 1 beat/cycle while the routed master holds `tready=1`.
- Backpressure: the routed master drops `tready` → one more beat is absorbed into skid → `s_axis_tready`=0 from the following cycle.
- A stalled master blocks all routes, including drop, until it drains (head-of-line blocking).
- The output payload is held stable while `tvalid=1 && tready=0`.
- Reset mid-packet: all state clears immediately and the partial packet is lost. The first beat accepted after reset is treated as a new packet and `sel` is sampled.

## Test plan
- `sel`=1, 4-beat packet 0x000001..0x000004 (tlast on beat 4), all ready=1 → appears only on m1, one cycle after each input beat, with tlast on beat 4; m0/m2 tvalid stay 0.
- `sel`=0 at the first beat, `sel` changed to 2 at beat 2 of a 3-beat packet → all 3 beats on m0. A following 1-beat packet goes to m2.
- `sel`=2, continuous stream, `m2_axis_tready` low for 3 cycles mid-packet → exactly one beat is buffered in skid and `s_axis_tready` falls one cycle later; after ready returns there is no loss or duplication and order is preserved.
- `sel`=3, two 5-beat packets → no master tvalid; s side is never stalled; `drop_cnt`=2.
- `rst` pulsed during beat 3 of an m0 packet with `sel`=1 → outputs and state are at reset values during `rst`; the first beat afterwards is routed to m1.
- Preload `drop_cnt` to 0xFFFF via 65535 dropped packets (or force), then drop one more → `drop_cnt` stays 0xFFFF.
